demux2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer with valid/ready handshakes: the steering counterpart of the 2:1 mux2 datapath selector.
- Takes one input word per accepted transfer and routes it, by a select bit, into a one-entry holding register for output A or output B.
- Each output drains independently to its own consumer.
- Used in the datapath wherever one producer must feed two sinks, for example splitting a result bus between register-file writeback and the memory store path.

---
 rtl/demux2_stream.sv | 61 ++++++
 tb/tb_demux2_stream.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 valid/ready stream demultiplexer with per-output transfer counters
module demux2_stream #(
  parameter int n  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [n-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [n-1:0]  a_data,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [n-1:0]  b_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [CW-1:0] a_count,
  output logic [CW-1:0] b_count
);
  logic [n-1:0]  a_data_q, a_data_d, b_data_q, b_data_d;
  logic          a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [CW-1:0] a_count_q, a_count_d, b_count_q, b_count_d;
  logic          acc_a, acc_b;
  assign in_ready = in_sel ? (!b_valid_q || b_ready) : (!a_valid_q || a_ready);
  assign acc_a    = in_valid && in_ready && !in_sel;
  assign acc_b    = in_valid && in_ready && in_sel;
  // next state: accept loads the selected slot, drain without accept empties it
  always_comb begin
    a_valid_d = acc_a || (a_valid_q && !a_ready);
    b_valid_d = acc_b || (b_valid_q && !b_ready);
    a_data_d  = acc_a ? in_data : a_data_q;
    b_data_d  = acc_b ? in_data : b_data_q;
    a_count_d = acc_a ? a_count_q + 1'b1 : a_count_q;
    b_count_d = acc_b ? b_count_q + 1'b1 : b_count_q;
  end
  // holding registers and counters, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end
  assign a_data  = a_data_q;
  assign b_data  = b_data_q;
  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;
  assign a_count = a_count_q;
  assign b_count = b_count_q;
endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed self-checking bench for demux2_stream
module tb_demux2_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_ready = 1'b0;
  logic        b_ready = 1'b0;
  logic [7:0]  a_count, b_count;
  int checks = 0;
  int failures = 0;

  demux2_stream #(.n(32), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) step();
    check("rst_a_valid", 64'(a_valid), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_a_data", 64'(a_data), 64'd0);
    check("rst_b_data", 64'(b_data), 64'd0);
    check("rst_a_count", 64'(a_count), 64'd0);
    check("rst_b_count", 64'(b_count), 64'd0);
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA_AAAA;
    #1;
    check("t1_in_ready", 64'(in_ready), 64'd1);
    step();
    check("t1_a_valid", 64'(a_valid), 64'd1);
    check("t1_a_data", 64'(a_data), 64'hAAAA_AAAA);
    check("t1_a_count", 64'(a_count), 64'd1);
    check("t1_b_valid", 64'(b_valid), 64'd0);
    check("t1_b_count", 64'(b_count), 64'd0);
    in_data = 32'h1234_5678;
    #1;
    check("t2_blocked_ready", 64'(in_ready), 64'd0);
    step();
    check("t2_blocked_count", 64'(a_count), 64'd1);
    check("t2_blocked_data", 64'(a_data), 64'hAAAA_AAAA);
    in_sel = 1'b1; in_data = 32'h5555_5555;
    #1;
    check("t2_b_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("t2_b_valid", 64'(b_valid), 64'd1);
    check("t2_b_data", 64'(b_data), 64'h5555_5555);
    check("t2_b_count", 64'(b_count), 64'd1);
    check("t2_a_data", 64'(a_data), 64'hAAAA_AAAA);
    step();
    check("idle_b_count", 64'(b_count), 64'd1);
    check("idle_a_count", 64'(a_count), 64'd1);
    a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      #1;
      check("t3_in_ready", 64'(in_ready), 64'd1);
      step();
      check("t3_a_valid", 64'(a_valid), 64'd1);
      check("t3_a_data", 64'(a_data), 64'(i));
    end
    in_valid = 1'b0;
    check("t3_a_count", 64'(a_count), 64'd5);
    step();
    check("t3_drain_a", 64'(a_valid), 64'd0);
    check("t3_b_held", 64'(b_valid), 64'd1);
    a_ready = 1'b0; b_ready = 1'b1;
    step();
    check("t3_drain_b", 64'(b_valid), 64'd0);
    b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0000_00CC;
    step();
    in_sel = 1'b1; in_data = 32'hFFFF_FF33;
    step();
    in_valid = 1'b0;
    check("t4_a_valid", 64'(a_valid), 64'd1);
    check("t4_b_valid", 64'(b_valid), 64'd1);
    check("t4_a_data", 64'(a_data), 64'h0000_00CC);
    check("t4_b_data", 64'(b_data), 64'hFFFF_FF33);
    check("t4_a_count", 64'(a_count), 64'd6);
    check("t4_b_count", 64'(b_count), 64'd2);
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    check("t4_a_drained", 64'(a_valid), 64'd0);
    check("t4_b_still", 64'(b_valid), 64'd1);
    check("t4_b_data_kept", 64'(b_data), 64'hFFFF_FF33);
    b_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
    for (int i = 0; i < 254; i++) begin
      in_data = 32'(i);
      step();
    end
    check("t5_b_wrap0", 64'(b_count), 64'd0);
    in_data = 32'hDEAD_BEEF;
    step();
    in_data = 32'hCAFE_F00D;
    step();
    in_valid = 1'b0;
    check("t5_b_count", 64'(b_count), 64'd2);
    check("t5_a_count", 64'(a_count), 64'd6);
    check("t5_b_data", 64'(b_data), 64'hCAFE_F00D);
    check("t5_b_valid", 64'(b_valid), 64'd1);
    step();
    b_ready = 1'b0;
    check("t5_b_drained", 64'(b_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h100 + 32'(i);
      step();
    end
    a_ready = 1'b0; b_ready = 1'b1; in_sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h200 + 32'(i);
      step();
    end
    in_valid = 1'b0; b_ready = 1'b0;
    check("t6_a_count", 64'(a_count), 64'd3);
    check("t6_b_count", 64'(b_count), 64'd5);
    check("t6_a_data", 64'(a_data), 64'h102);
    check("t6_b_data", 64'(b_data), 64'h204);
    check("t6_a_valid", 64'(a_valid), 64'd1);
    check("t6_b_valid", 64'(b_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_a_valid", 64'(a_valid), 64'd0);
    check("t6_rst_b_valid", 64'(b_valid), 64'd0);
    check("t6_rst_a_data", 64'(a_data), 64'd0);
    check("t6_rst_b_data", 64'(b_data), 64'd0);
    check("t6_rst_a_count", 64'(a_count), 64'd0);
    check("t6_rst_b_count", 64'(b_count), 64'd0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h7777_7777;
    step();
    check("t6_no_accept_in_rst", 64'(a_count), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
